// File: rtl/sha_result_checker.sv
// Result checker for the double-SHA core: tracks nonces, compares each hash with the
// share target in a two-stage pipeline and queues hits in a compacting FIFO.
module sha_result_checker #(
    parameter int FIFO_DEPTH  = 4,
    parameter bit FLUSH_STALE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hash_valid,
    input  logic            hash_newblock,
    input  logic [7:0][31:0] doublehash,
    input  logic [31:0]     nonce_base,
    input  logic [255:0]    target,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [31:0]     result_nonce,
    output logic [7:0]      result_block,
    output logic [31:0]     hash_count,
    output logic [15:0]     drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [31:0]  base_q, base_d, nidx_q, nidx_d, cur_idx_s;
    logic [7:0]   blk_q, blk_d;
    logic [255:0] tgt_q, tgt_d, cur_tgt_s;
    logic [7:0]   lt_d, eq_d;

    logic         s1_vld_q, s1_nb_q;
    logic [31:0]  s1_nonce_q;
    logic [7:0]   s1_blk_q, s1_lt_q, s1_eq_q;
    logic         hit_s, done_s;

    logic         s2_vld_q, s2_hit_q, s2_nb_q;
    logic [31:0]  s2_nonce_q;
    logic [7:0]   s2_blk_q;

    logic [31:0]          ent_nonce_q [FIFO_DEPTH];
    logic [31:0]          ent_nonce_d [FIFO_DEPTH];
    logic [7:0]           ent_blk_q   [FIFO_DEPTH];
    logic [7:0]           ent_blk_d   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ent_vld_q, ent_vld_d, keep_s;
    logic [CW-1:0]        wr_s;
    logic                 pop_s, flush_s, drop_s;
    logic [31:0]          hash_count_q, hash_count_d;
    logic [15:0]          drop_count_q, drop_count_d;

    // Nonce/target tracking; the newblock hash is compared against the freshly sampled target.
    always_comb begin
        base_d    = base_q;
        nidx_d    = nidx_q;
        blk_d     = blk_q;
        tgt_d     = tgt_q;
        cur_idx_s = nidx_q;
        cur_tgt_s = tgt_q;
        if (hash_valid) begin
            if (hash_newblock) begin
                blk_d     = blk_q + 8'd1;
                base_d    = nonce_base;
                tgt_d     = target;
                cur_idx_s = 32'd0;
                cur_tgt_s = target;
            end else begin
                cur_idx_s = nidx_q;
            end
            nidx_d = cur_idx_s + 32'd1;
        end else begin
            nidx_d = nidx_q;
        end
        for (int k = 0; k < 8; k++) begin
            lt_d[k] = bswap32(doublehash[k]) <  cur_tgt_s[32*k +: 32];
            eq_d[k] = bswap32(doublehash[k]) == cur_tgt_s[32*k +: 32];
        end
    end

    // Resolve V <= target from the per-word flags, most significant word first.
    always_comb begin
        hit_s  = 1'b1;
        done_s = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (!done_s && !s1_eq_q[k]) begin
                hit_s  = s1_lt_q[k];
                done_s = 1'b1;
            end else begin
                done_s = done_s;
            end
        end
    end

    // Tracking registers and the two compare stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= 32'd0;
            nidx_q     <= 32'd0;
            blk_q      <= 8'd0;
            tgt_q      <= 256'd0;
            s1_vld_q   <= 1'b0;
            s1_nb_q    <= 1'b0;
            s1_nonce_q <= 32'd0;
            s1_blk_q   <= 8'd0;
            s1_lt_q    <= 8'd0;
            s1_eq_q    <= 8'd0;
            s2_vld_q   <= 1'b0;
            s2_hit_q   <= 1'b0;
            s2_nb_q    <= 1'b0;
            s2_nonce_q <= 32'd0;
            s2_blk_q   <= 8'd0;
        end else begin
            base_q     <= base_d;
            nidx_q     <= nidx_d;
            blk_q      <= blk_d;
            tgt_q      <= tgt_d;
            s1_vld_q   <= hash_valid;
            s1_nb_q    <= hash_valid && hash_newblock;
            s1_nonce_q <= base_d + cur_idx_s;
            s1_blk_q   <= blk_d;
            s1_lt_q    <= lt_d;
            s1_eq_q    <= eq_d;
            s2_vld_q   <= s1_vld_q;
            s2_hit_q   <= s1_vld_q && hit_s;
            s2_nb_q    <= s1_nb_q;
            s2_nonce_q <= s1_nonce_q;
            s2_blk_q   <= s1_blk_q;
        end
    end

    // FIFO update: drop stale/popped entries, compact toward slot 0, then append the S2 hit.
    always_comb begin
        pop_s     = ent_vld_q[0] && result_ready;
        flush_s   = FLUSH_STALE && s2_vld_q && s2_nb_q;
        ent_vld_d = '0;
        wr_s      = '0;
        drop_s    = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            keep_s[i]      = ent_vld_q[i] && !(flush_s && (ent_blk_q[i] != s2_blk_q));
            ent_nonce_d[i] = 32'd0;
            ent_blk_d[i]   = 8'd0;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (keep_s[i] && !((i == 0) && pop_s)) begin
                ent_nonce_d[wr_s[AW-1:0]] = ent_nonce_q[i];
                ent_blk_d[wr_s[AW-1:0]]   = ent_blk_q[i];
                ent_vld_d[wr_s[AW-1:0]]   = 1'b1;
                wr_s = wr_s + 1'b1;
            end else begin
                wr_s = wr_s;
            end
        end
        if (s2_hit_q) begin
            if (wr_s < CW'(FIFO_DEPTH)) begin
                ent_nonce_d[wr_s[AW-1:0]] = s2_nonce_q;
                ent_blk_d[wr_s[AW-1:0]]   = s2_blk_q;
                ent_vld_d[wr_s[AW-1:0]]   = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            drop_s = 1'b0;
        end
        hash_count_d = hash_count_q + {31'd0, s2_vld_q};
        if (drop_s && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    // FIFO storage and statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld_q    <= '0;
            hash_count_q <= 32'd0;
            drop_count_q <= 16'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_nonce_q[i] <= 32'd0;
                ent_blk_q[i]   <= 8'd0;
            end
        end else begin
            ent_vld_q    <= ent_vld_d;
            hash_count_q <= hash_count_d;
            drop_count_q <= drop_count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_nonce_q[i] <= ent_nonce_d[i];
                ent_blk_q[i]   <= ent_blk_d[i];
            end
        end
    end

    assign result_valid = ent_vld_q[0];
    assign result_nonce = ent_nonce_q[0];
    assign result_block = ent_blk_q[0];
    assign hash_count   = hash_count_q;
    assign drop_count   = drop_count_q;
endmodule
